// File: rtl/pattern_seq_detect.sv
// Serial pattern detector: compares a valid-qualified bit stream against a
// runtime-loadable masked pattern, with overlap control and a saturating match counter.
module pattern_seq_detect #(
  parameter int unsigned          PAT_W   = 8,
  parameter logic [PAT_W-1:0]     PATTERN = 8'b01101110,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed,
  input  logic             seed_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             cnt_clr,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count,
  output logic             o_armed
);

  localparam int unsigned FC_W = $clog2(PAT_W + 1);
  localparam logic [FC_W-1:0]  FC_FULL = FC_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   sh_q, sh_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   msk_q, msk_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               done_d;
  logic               armed_d;

  logic [PAT_W-1:0]   sh_shift_c;
  logic [FC_W-1:0]    fc_inc_c;
  logic               hit_c;
  logic               match_c;

  // History after accepting the current bit, and the saturating fill count.
  assign sh_shift_c = {sh_q[PAT_W-2:0], seed};
  assign fc_inc_c   = (fc_q == FC_FULL) ? FC_FULL : fc_q + FC_W'(1);
  assign hit_c      = (fc_inc_c == FC_FULL) && (((sh_shift_c ^ pat_q) & msk_q) == '0);

  // Next-state: load beats accept; a match in non-overlap mode empties the fill count.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    fc_d    = fc_q;
    pat_d   = pat_q;
    msk_d   = msk_q;
    match_c = 1'b0;
    if (pat_load) begin
      pat_d   = pat_in;
      msk_d   = mask_in;
      sh_d    = '0;
      fc_d    = '0;
      state_d = FILL;
    end else if (seed_valid) begin
      sh_d    = sh_shift_c;
      fc_d    = fc_inc_c;
      state_d = (fc_inc_c == FC_FULL) ? ARMED : FILL;
      if (hit_c) begin
        match_c = 1'b1;
        if (!overlap) begin
          fc_d    = '0;
          state_d = FILL;
        end
      end
    end
  end

  // Counter and registered output values.
  always_comb begin
    cnt_d   = o_count;
    done_d  = match_c;
    armed_d = (fc_d == FC_FULL);
    if (match_c) begin
      if (cnt_clr) begin
        cnt_d = CNT_W'(1);
      end else if (o_count != CNT_MAX) begin
        cnt_d = o_count + CNT_W'(1);
      end
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      sh_q    <= '0;
      fc_q    <= '0;
      pat_q   <= PATTERN;
      msk_q   <= '1;
      o_done  <= 1'b0;
      o_count <= '0;
      o_armed <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      fc_q    <= fc_d;
      pat_q   <= pat_d;
      msk_q   <= msk_d;
      o_done  <= done_d;
      o_count <= cnt_d;
      o_armed <= armed_d;
    end
  end

endmodule
